bp_fifo_2rp_ctrl: RTL and testbench

//  Pointer/flow-control sequencer for a 2-read-port broadcast FIFO built on bsg_mem_2r1w_sync.

---
 rtl/bp_fifo_pkg.sv | 15 +
 rtl/bp_fifo_rd_port_ctrl.sv | 59 +++++
 rtl/bp_fifo_2rp_ctrl.sv | 94 +++++++++
 tb/tb_bp_fifo_2rp_ctrl.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/bp_fifo_pkg.sv
// bp_fifo_pkg
//   Shared helpers for the 2-read-port broadcast FIFO controller.
//   safe_clog2 : ceil(log2(n)), never less than 1 (a 1-entry address still needs 1 bit)
//   ptr_width  : address width plus one wrap bit, so full and empty stay distinguishable
package bp_fifo_pkg;

  function automatic int safe_clog2(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int ptr_width(input int els);
    return safe_clog2(els) + 1;
  endfunction

endpackage

// File: rtl/bp_fifo_rd_port_ctrl.sv
// bp_fifo_rd_port_ctrl
//   Per-consumer read sequencer. It issues sync-memory reads so the head word
//   is held in the memory output register, and it tracks whether that head is
//   still owned by the consumer.
// Ports
//   clk_i, reset_i : clock and synchronous active-high reset
//   w_ptr_i        : producer write pointer, including the wrap bit
//   yumi_i         : consumer takes the head this cycle
//   v_o            : head valid
//   rd_o           : memory read enable for this port
//   addr_o         : memory read address for this port
//   occ_o          : entries written but not yet read-issued on this port
module bp_fifo_rd_port_ctrl
  import bp_fifo_pkg::*;
#(
  parameter  int els_p        = 16,
  localparam int lg_els_lp    = safe_clog2(els_p),
  localparam int ptr_width_lp = ptr_width(els_p)
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic [ptr_width_lp-1:0] w_ptr_i,
  input  logic                    yumi_i,
  output logic                    v_o,
  output logic                    rd_o,
  output logic [lg_els_lp-1:0]    addr_o,
  output logic [ptr_width_lp-1:0] occ_o
);

  logic [ptr_width_lp-1:0] r_ptr;
  logic                    r_valid;
  logic                    w_rd;

  // Wrap-bit arithmetic: the difference is the occupancy modulo 2*els_p.
  assign occ_o  = w_ptr_i - r_ptr;

  // Refill the output register whenever it is empty or being consumed this
  // cycle. The slot is released here, not at yumi: the word now lives in the
  // memory output latch until the next read on this port.
  assign w_rd   = (occ_o != '0) & (~r_valid | yumi_i) & ~reset_i;

  assign rd_o   = w_rd;
  assign addr_o = r_ptr[lg_els_lp-1:0];
  // Masked by reset so a consumer never sees a head that is being discarded.
  assign v_o    = r_valid & ~reset_i;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_ptr   <= '0;
      r_valid <= 1'b0;
    end else if (w_rd) begin
      r_ptr   <= r_ptr + ptr_width_lp'(1);
      r_valid <= 1'b1;
    end else if (yumi_i) begin
      r_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/bp_fifo_2rp_ctrl.sv
// bp_fifo_2rp_ctrl
//   Pointer and flow-control sequencer for a broadcast FIFO built on a
//   2-read/1-write sync-read memory. One producer (valid/ready) feeds two
//   independent consumers (valid/yumi); each consumer sees every entry once,
//   in order. The memory itself is instantiated by the parent.
// Ports
//   clk_i, reset_i            : clock and synchronous active-high reset
//   v_i, data_i, ready_o      : producer handshake
//   v0_o/v1_o, data0_o/data1_o: consumer head valid and data
//   yumi0_i/yumi1_i           : consumer takes the head
//   mem_w_*                   : memory write port
//   mem_r0_*/mem_r1_*         : memory read ports; data is valid the cycle after v
module bp_fifo_2rp_ctrl
  import bp_fifo_pkg::*;
#(
  parameter  int width_p      = 16,
  parameter  int els_p        = 16,
  localparam int lg_els_lp    = safe_clog2(els_p),
  localparam int ptr_width_lp = ptr_width(els_p)
) (
  input  logic                 clk_i,
  input  logic                 reset_i,

  input  logic                 v_i,
  input  logic [width_p-1:0]   data_i,
  output logic                 ready_o,

  output logic                 v0_o,
  output logic [width_p-1:0]   data0_o,
  input  logic                 yumi0_i,
  output logic                 v1_o,
  output logic [width_p-1:0]   data1_o,
  input  logic                 yumi1_i,

  output logic                 mem_w_v_o,
  output logic [lg_els_lp-1:0] mem_w_addr_o,
  output logic [width_p-1:0]   mem_w_data_o,
  output logic                 mem_r0_v_o,
  output logic [lg_els_lp-1:0] mem_r0_addr_o,
  input  logic [width_p-1:0]   mem_r0_data_i,
  output logic                 mem_r1_v_o,
  output logic [lg_els_lp-1:0] mem_r1_addr_o,
  input  logic [width_p-1:0]   mem_r1_data_i
);

  localparam logic [ptr_width_lp-1:0] els_lp = ptr_width_lp'(els_p);

  logic [ptr_width_lp-1:0] r_w_ptr;
  logic [ptr_width_lp-1:0] w_occ0, w_occ1;
  logic                    w_full;
  logic                    w_we;

  bp_fifo_rd_port_ctrl #(.els_p(els_p)) u_rd0 (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .w_ptr_i (r_w_ptr),
    .yumi_i  (yumi0_i),
    .v_o     (v0_o),
    .rd_o    (mem_r0_v_o),
    .addr_o  (mem_r0_addr_o),
    .occ_o   (w_occ0)
  );

  bp_fifo_rd_port_ctrl #(.els_p(els_p)) u_rd1 (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .w_ptr_i (r_w_ptr),
    .yumi_i  (yumi1_i),
    .v_o     (v1_o),
    .rd_o    (mem_r1_v_o),
    .addr_o  (mem_r1_addr_o),
    .occ_o   (w_occ1)
  );

  // The slower port sets the fill level. No write-through-read when full:
  // that keeps the write and read addresses distinct in every cycle.
  assign w_full       = (w_occ0 == els_lp) | (w_occ1 == els_lp);
  assign ready_o      = ~w_full & ~reset_i;
  assign w_we         = v_i & ready_o;

  assign mem_w_v_o    = w_we;
  assign mem_w_addr_o = r_w_ptr[lg_els_lp-1:0];
  assign mem_w_data_o = data_i;

  // The memory output register is the head storage for each port.
  assign data0_o      = mem_r0_data_i;
  assign data1_o      = mem_r1_data_i;

  always_ff @(posedge clk_i) begin
    if (reset_i)   r_w_ptr <= '0;
    else if (w_we) r_w_ptr <= r_w_ptr + ptr_width_lp'(1);
  end

endmodule

// File: tb/tb_bp_fifo_2rp_ctrl.sv
// tb_bp_fifo_2rp_ctrl
//   Directed bench with a behavioural 2r1w sync memory and per-port
//   scoreboards: every accepted word is pushed to both queues and popped
//   and compared when the matching consumer takes its head.
module tb_bp_fifo_2rp_ctrl;

  localparam int W = 16;
  localparam int E = 16;
  localparam int L = 4;

  logic         clk = 1'b0;
  logic         reset_i, v_i, ready_o;
  logic [W-1:0] data_i;
  logic         v0_o, v1_o, yumi0_i, yumi1_i;
  logic [W-1:0] data0_o, data1_o;
  logic         mem_w_v_o, mem_r0_v_o, mem_r1_v_o;
  logic [L-1:0] mem_w_addr_o, mem_r0_addr_o, mem_r1_addr_o;
  logic [W-1:0] mem_w_data_o, mem_r0_data_i, mem_r1_data_i;

  logic y0_en, y1_en, y0_force;
  assign yumi0_i = (y0_en & v0_o) | y0_force;
  assign yumi1_i = y1_en & v1_o;

  always #5 clk = ~clk;

  bp_fifo_2rp_ctrl #(.width_p(W), .els_p(E)) dut (
    .clk_i(clk), .reset_i(reset_i),
    .v_i(v_i), .data_i(data_i), .ready_o(ready_o),
    .v0_o(v0_o), .data0_o(data0_o), .yumi0_i(yumi0_i),
    .v1_o(v1_o), .data1_o(data1_o), .yumi1_i(yumi1_i),
    .mem_w_v_o(mem_w_v_o), .mem_w_addr_o(mem_w_addr_o), .mem_w_data_o(mem_w_data_o),
    .mem_r0_v_o(mem_r0_v_o), .mem_r0_addr_o(mem_r0_addr_o), .mem_r0_data_i(mem_r0_data_i),
    .mem_r1_v_o(mem_r1_v_o), .mem_r1_addr_o(mem_r1_addr_o), .mem_r1_data_i(mem_r1_data_i)
  );

  // Sync-read memory: outputs hold when not read.
  logic [W-1:0] mem [0:E-1];
  always @(posedge clk) begin
    if (mem_w_v_o)  mem[mem_w_addr_o] <= mem_w_data_o;
    if (mem_r0_v_o) mem_r0_data_i <= mem[mem_r0_addr_o];
    if (mem_r1_v_o) mem_r1_data_i <= mem[mem_r1_addr_o];
  end

  int n_chk = 0, n_fail = 0;
  int wr_cnt = 0, pop0 = 0, pop1 = 0, illegal0 = 0;
  bit fired;
  logic [W-1:0] q0[$], q1[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Negedge half: record handshakes that will take effect at the next posedge.
  task automatic neg();
    @(negedge clk);
    if (reset_i) begin
      q0.delete(); q1.delete();
    end else begin
      if (v_i && ready_o) begin
        q0.push_back(data_i); q1.push_back(data_i); wr_cnt++; fired = 1'b1;
      end
      if (yumi0_i && v0_o) begin
        pop0++;
        chk("p0_pending", q0.size() > 0, 1'b1);
        if (q0.size() > 0) chk("p0_data", data0_o, q0.pop_front());
      end
      if (yumi1_i && v1_o) begin
        pop1++;
        chk("p1_pending", q1.size() > 0, 1'b1);
        if (q1.size() > 0) chk("p1_data", data1_o, q1.pop_front());
      end
      if (yumi0_i && !v0_o) illegal0++;
    end
  endtask

  task automatic pos();
    @(posedge clk); #1;
    if (fired) data_i = data_i + 1'b1;
    fired = 1'b0;
  endtask

  task automatic cyc();
    neg(); pos();
  endtask

  int base, p0b, p1b, cycles;

  initial begin
    reset_i = 1'b1; v_i = 1'b0; data_i = '0;
    y0_en = 1'b0; y1_en = 1'b0; y0_force = 1'b0; fired = 1'b0;
    pos();
    neg();
    chk("rst_ready", ready_o, 0);
    chk("rst_v0", v0_o, 0);
    chk("rst_v1", v1_o, 0);
    chk("rst_wv", mem_w_v_o, 0);
    chk("rst_r0v", mem_r0_v_o, 0);
    chk("rst_r1v", mem_r1_v_o, 0);
    pos();
    reset_i = 1'b0;

    // 1: single word latency
    v_i = 1'b1; data_i = 16'hA5A5;
    neg();
    chk("t1_ready", ready_o, 1);
    chk("t1_wv", mem_w_v_o, 1);
    chk("t1_waddr", mem_w_addr_o, 0);
    chk("t1_wdata", mem_w_data_o, 16'hA5A5);
    pos();
    v_i = 1'b0;
    neg();
    chk("t1_v0_early", v0_o, 0);
    chk("t1_r0v", mem_r0_v_o, 1);
    chk("t1_r0addr", mem_r0_addr_o, 0);
    chk("t1_r1v", mem_r1_v_o, 1);
    pos();
    neg();
    chk("t1_v0", v0_o, 1);
    chk("t1_v1", v1_o, 1);
    chk("t1_d0", data0_o, 16'hA5A5);
    chk("t1_d1", data1_o, 16'hA5A5);
    pos();
    y0_en = 1'b1; y1_en = 1'b1;
    cyc();
    y0_en = 1'b0; y1_en = 1'b0;
    neg();
    chk("t1_drained_v0", v0_o, 0);
    chk("t1_q_empty", q0.size() + q1.size(), 0);
    pos();

    // 2: fill with both consumers stalled; one head plus els_p queued
    data_i = '0; v_i = 1'b1; base = wr_cnt;
    repeat (24) cyc();
    chk("t2_accepted", wr_cnt - base, E + 1);
    neg();
    chk("t2_ready_full", ready_o, 0);
    chk("t2_v0", v0_o, 1);
    pos();

    // 3: port 0 drains, port 1 stalled keeps the producer blocked
    y0_en = 1'b1; base = wr_cnt; p0b = pop0;
    repeat (24) cyc();
    chk("t3_no_write", wr_cnt - base, 0);
    chk("t3_pop0", pop0 - p0b, E + 1);
    chk("t3_q0_empty", q0.size(), 0);
    neg();
    chk("t3_ready", ready_o, 0);
    chk("t3_v0", v0_o, 0);
    chk("t3_v1", v1_o, 1);
    pos();
    v_i = 1'b0; y0_en = 1'b0; y1_en = 1'b1;
    repeat (24) cyc();
    chk("t3_q1_empty", q1.size(), 0);
    y1_en = 1'b0;

    // 4: full-rate streaming through both ports with pointer wrap
    y0_en = 1'b1; y1_en = 1'b1; v_i = 1'b1;
    base = wr_cnt; p0b = pop0; p1b = pop1; cycles = 0;
    while ((wr_cnt - base) < 40 && cycles < 200) begin
      cyc(); cycles++;
    end
    chk("t4_accepted", wr_cnt - base, 40);
    chk("t4_cycles", cycles, 40);
    chk("t4_rate0", pop0 - p0b, 38);
    chk("t4_rate1", pop1 - p1b, 38);
    v_i = 1'b0;
    repeat (4) cyc();
    chk("t4_pop0", pop0 - p0b, 40);
    chk("t4_pop1", pop1 - p1b, 40);
    chk("t4_q_empty", q0.size() + q1.size(), 0);
    y0_en = 1'b0; y1_en = 1'b0;

    // 5: reset mid-stream
    v_i = 1'b1;
    repeat (5) cyc();
    v_i = 1'b0;
    cyc();
    neg();
    chk("t5_v0_before", v0_o, 1);
    chk("t5_q0_depth", q0.size(), 5);
    pos();
    reset_i = 1'b1;
    neg();
    chk("t5_rst_ready", ready_o, 0);
    chk("t5_rst_r0v", mem_r0_v_o, 0);
    chk("t5_rst_wv", mem_w_v_o, 0);
    pos();
    neg();
    chk("t5_v0", v0_o, 0);
    chk("t5_v1", v1_o, 0);
    chk("t5_ready", ready_o, 0);
    pos();
    reset_i = 1'b0;
    neg();
    chk("t5_ready_after", ready_o, 1);
    chk("t5_r0v_empty", mem_r0_v_o, 0);
    chk("t5_r1v_empty", mem_r1_v_o, 0);
    pos();
    neg();
    chk("t5_v0_after", v0_o, 0);
    pos();

    // 6: illegal yumi on an empty port is ignored
    y0_force = 1'b1;
    neg();
    chk("t6_v0_idle", v0_o, 0);
    pos();
    y0_force = 1'b0;
    neg();
    chk("t6_flagged", illegal0, 1);
    chk("t6_v0_hold", v0_o, 0);
    chk("t6_r0v", mem_r0_v_o, 0);
    pos();
    v_i = 1'b1; data_i = 16'h1234; p0b = pop0;
    neg();
    chk("t6_waddr", mem_w_addr_o, 0);
    pos();
    v_i = 1'b0; y0_en = 1'b1; y1_en = 1'b1;
    repeat (4) cyc();
    chk("t6_pop0", pop0 - p0b, 1);
    chk("t6_q_empty", q0.size() + q1.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
